scoreboard_issue: RTL and testbench

- Parametrised N-wide in-order issue gate for the dispatch stage.
- Replaces the single-bit register-availability tracking with a per-register latency countdown scoreboard, plus a sticky "unknown latency" bit for loads and other variable-latency writers.
- Computes the per-slot issue mask from four checks: scoreboard readiness, intra-group RAW hazards, WAW ordering, and single-issue constraints.
- Also keeps PMU counters.

---
 rtl/scoreboard_issue_if.sv | 40 ++++
 rtl/scoreboard_issue.sv | 155 +++++++++++++++
 tb/tb_scoreboard_issue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/scoreboard_issue_if.sv
// Dispatch-to-issue-gate bus: per-slot instruction fields, write-back releases and the
// issue/accept mask, register busy vector and PMU counters flowing back.
interface scoreboard_issue_if #(
   parameter int ISSUE_WIDTH = 2,
   parameter int GPR_NUM     = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int LAT_W       = 3,
   parameter int WB_PORTS    = 2
);
   // Handshake: instr_valid_i[i] offers slot i; issue_o[i] is the same-cycle accept.
   // An instruction is consumed on the rising clock edge at which both are high;
   // issue_o is a prefix of the valid slots and is never high during stall or flush.
   logic [ISSUE_WIDTH-1:0]              instr_valid_i;
   logic [ISSUE_WIDTH*2-1:0]            rs_valid_i;
   logic [ISSUE_WIDTH*2*REG_ADDR_W-1:0] rs_addr_i;
   logic [ISSUE_WIDTH-1:0]              rd_valid_i;
   logic [ISSUE_WIDTH*REG_ADDR_W-1:0]   rd_addr_i;
   logic [ISSUE_WIDTH*LAT_W-1:0]        rd_latency_i;
   logic [ISSUE_WIDTH-1:0]              single_issue_i;
   logic                                stall_i;
   logic                                flush_i;
   logic [WB_PORTS-1:0]                 wb_valid_i;
   logic [WB_PORTS*REG_ADDR_W-1:0]      wb_addr_i;
   logic [ISSUE_WIDTH-1:0]              issue_o;
   logic [GPR_NUM-1:0]                  busy_o;
   logic [31:0]                         issued_cnt_o;
   logic [31:0]                         dep_stall_cnt_o;

   modport master (
      output instr_valid_i, rs_valid_i, rs_addr_i, rd_valid_i, rd_addr_i, rd_latency_i,
             single_issue_i, stall_i, flush_i, wb_valid_i, wb_addr_i,
      input  issue_o, busy_o, issued_cnt_o, dep_stall_cnt_o
   );

   modport slave (
      input  instr_valid_i, rs_valid_i, rs_addr_i, rd_valid_i, rd_addr_i, rd_latency_i,
             single_issue_i, stall_i, flush_i, wb_valid_i, wb_addr_i,
      output issue_o, busy_o, issued_cnt_o, dep_stall_cnt_o
   );
endinterface

// File: rtl/scoreboard_issue.sv
// In-order N-wide issue gate: per-register latency countdown plus sticky unknown-latency
// bit, intra-group RAW/WAW/single-issue checks, and issue/dependency-stall PMU counters.
module scoreboard_issue #(
   parameter int ISSUE_WIDTH = 2,
   parameter int GPR_NUM     = 32,
   parameter int REG_ADDR_W  = 5,
   parameter int LAT_W       = 3,
   parameter int WB_PORTS    = 2
) (
   input logic               clk,
   input logic               rst,
   scoreboard_issue_if.slave bus
);

   logic [GPR_NUM-1:0][LAT_W-1:0] cnt_q, cnt_d;
   logic [GPR_NUM-1:0]            unk_q, unk_d;
   logic [31:0]                   issued_cnt_q, issued_cnt_d;
   logic [31:0]                   dep_stall_cnt_q, dep_stall_cnt_d;

   logic [GPR_NUM-1:0]     ready;
   logic [ISSUE_WIDTH-1:0] issue_raw;
   logic [ISSUE_WIDTH-1:0] issue;
   logic                   prev_ok;
   logic                   slot_ok;
   logic [REG_ADDR_W-1:0]  src_addr;
   logic [REG_ADDR_W-1:0]  dst_addr;
   logic [REG_ADDR_W-1:0]  older_rd;
   logic [LAT_W-1:0]       dst_lat;
   logic [REG_ADDR_W-1:0]  wr_addr;
   logic [LAT_W-1:0]       wr_lat;
   logic [REG_ADDR_W-1:0]  wb_addr;
   logic [31:0]            issue_pop;

   always_comb begin
      for (int r = 0; r < GPR_NUM; r++) begin
         ready[r] = ((cnt_q[r] == '0) && !unk_q[r]) || (r == 0);
      end
   end

   // Slot checks evaluated oldest first; prev_ok enforces the in-order prefix.
   always_comb begin
      issue_raw = '0;
      prev_ok   = 1'b1;
      slot_ok   = 1'b0;
      src_addr  = '0;
      dst_addr  = '0;
      older_rd  = '0;
      dst_lat   = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         slot_ok = bus.instr_valid_i[i] && prev_ok;

         for (int s = 0; s < 2; s++) begin
            src_addr = bus.rs_addr_i[(2*i+s)*REG_ADDR_W +: REG_ADDR_W];
            if (bus.rs_valid_i[2*i+s]) begin
               if (!ready[src_addr]) slot_ok = 1'b0;
               for (int j = 0; j < i; j++) begin
                  older_rd = bus.rd_addr_i[j*REG_ADDR_W +: REG_ADDR_W];
                  if (bus.rd_valid_i[j] && (older_rd != '0) && (older_rd == src_addr)) begin
                     slot_ok = 1'b0;
                  end
               end
            end
         end

         // A fixed-latency write may overtake an older pending one only if it lands later.
         dst_addr = bus.rd_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
         dst_lat  = bus.rd_latency_i[i*LAT_W +: LAT_W];
         if (bus.rd_valid_i[i] && (dst_addr != '0)) begin
            if (dst_lat == '0) begin
               if (!ready[dst_addr]) slot_ok = 1'b0;
            end else if (unk_q[dst_addr] || (cnt_q[dst_addr] > (dst_lat - LAT_W'(1)))) begin
               slot_ok = 1'b0;
            end
         end

         if ((i > 0) && (bus.single_issue_i[i] || bus.single_issue_i[0])) slot_ok = 1'b0;

         issue_raw[i] = slot_ok;
         prev_ok      = slot_ok;
      end
   end

   assign issue = (rst || bus.stall_i || bus.flush_i) ? '0 : issue_raw;

   // Later issue writes override decrement/release; ascending order lets the youngest win.
   always_comb begin
      cnt_d   = cnt_q;
      unk_d   = unk_q;
      wr_addr = '0;
      wr_lat  = '0;
      wb_addr = '0;
      for (int r = 0; r < GPR_NUM; r++) begin
         cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - LAT_W'(1) : '0;
      end
      for (int p = 0; p < WB_PORTS; p++) begin
         wb_addr = bus.wb_addr_i[p*REG_ADDR_W +: REG_ADDR_W];
         if (bus.wb_valid_i[p]) unk_d[wb_addr] = 1'b0;
      end
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         wr_addr = bus.rd_addr_i[i*REG_ADDR_W +: REG_ADDR_W];
         wr_lat  = bus.rd_latency_i[i*LAT_W +: LAT_W];
         if (issue[i] && bus.rd_valid_i[i] && (wr_addr != '0)) begin
            if (wr_lat != '0) begin
               cnt_d[wr_addr] = wr_lat - LAT_W'(1);
               unk_d[wr_addr] = 1'b0;
            end else begin
               cnt_d[wr_addr] = '0;
               unk_d[wr_addr] = 1'b1;
            end
         end
      end
      cnt_d[0] = '0;
      unk_d[0] = 1'b0;
      if (bus.flush_i) begin
         cnt_d = '0;
         unk_d = '0;
      end
   end

   always_comb begin
      issue_pop = '0;
      for (int i = 0; i < ISSUE_WIDTH; i++) begin
         issue_pop = issue_pop + 32'(issue[i]);
      end
   end

   always_comb begin
      issued_cnt_d    = issued_cnt_q;
      dep_stall_cnt_d = dep_stall_cnt_q;
      if (!bus.stall_i && !bus.flush_i) begin
         issued_cnt_d = issued_cnt_q + issue_pop;
         if (bus.instr_valid_i[0] && !issue[0]) dep_stall_cnt_d = dep_stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q           <= '0;
         unk_q           <= '0;
         issued_cnt_q    <= '0;
         dep_stall_cnt_q <= '0;
      end else begin
         cnt_q           <= cnt_d;
         unk_q           <= unk_d;
         issued_cnt_q    <= issued_cnt_d;
         dep_stall_cnt_q <= dep_stall_cnt_d;
      end
   end

   assign bus.issue_o         = issue;
   assign bus.busy_o          = ~ready;
   assign bus.issued_cnt_o    = issued_cnt_q;
   assign bus.dep_stall_cnt_o = dep_stall_cnt_q;

endmodule

// File: tb/tb_scoreboard_issue.sv
// Directed bench for scoreboard_issue: hand-computed issue masks, busy bits and counters.
module tb_scoreboard_issue;

   logic clk;
   logic rst;
   int   n_chk;
   int   n_err;

   scoreboard_issue_if #(.ISSUE_WIDTH(2), .GPR_NUM(32), .REG_ADDR_W(5), .LAT_W(3), .WB_PORTS(2)) bus ();

   scoreboard_issue #(.ISSUE_WIDTH(2), .GPR_NUM(32), .REG_ADDR_W(5), .LAT_W(3), .WB_PORTS(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      bus.instr_valid_i  = '0;
      bus.rs_valid_i     = '0;
      bus.rs_addr_i      = '0;
      bus.rd_valid_i     = '0;
      bus.rd_addr_i      = '0;
      bus.rd_latency_i   = '0;
      bus.single_issue_i = '0;
      bus.stall_i        = 1'b0;
      bus.flush_i        = 1'b0;
      bus.wb_valid_i     = '0;
      bus.wb_addr_i      = '0;
   endtask

   task automatic set_slot(input int i, input logic v, input logic r0v, input logic [4:0] r0,
                           input logic r1v, input logic [4:0] r1, input logic rdv,
                           input logic [4:0] rd, input logic [2:0] lat, input logic si);
      bus.instr_valid_i[i]       = v;
      bus.rs_valid_i[2*i]        = r0v;
      bus.rs_addr_i[(2*i)*5 +: 5] = r0;
      bus.rs_valid_i[2*i+1]      = r1v;
      bus.rs_addr_i[(2*i+1)*5 +: 5] = r1;
      bus.rd_valid_i[i]          = rdv;
      bus.rd_addr_i[i*5 +: 5]    = rd;
      bus.rd_latency_i[i*3 +: 3] = lat;
      bus.single_issue_i[i]      = si;
   endtask

   // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      n_chk = 0;
      n_err = 0;
      rst   = 1'b1;
      idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
      #2;
      check("reset_issue", 64'(bus.issue_o), 64'h0);
      check("reset_busy", 64'(bus.busy_o), 64'h0);
      check("reset_issued", 64'(bus.issued_cnt_o), 64'd0);
      check("reset_dep", 64'(bus.dep_stall_cnt_o), 64'd0);
      tick();
      rst = 1'b0;
      idle();

      // Load r5 with unknown latency, consumer waits for write-back release.
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 3'd0, 1'b0);
      settle();
      check("t1_load_issue", 64'(bus.issue_o), 64'h1);
      tick(); idle();
      set_slot(0, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
      settle();
      check("t1_cons_blk0", 64'(bus.issue_o), 64'h0);
      check("t1_busy5", 64'(bus.busy_o[5]), 64'h1);
      check("t1_issued1", 64'(bus.issued_cnt_o), 64'd1);
      tick();
      bus.wb_valid_i[0]     = 1'b1;
      bus.wb_addr_i[4:0]    = 5'd5;
      settle();
      check("t1_cons_blk1", 64'(bus.issue_o), 64'h0);
      check("t1_dep1", 64'(bus.dep_stall_cnt_o), 64'd1);
      tick();
      bus.wb_valid_i = '0;
      settle();
      check("t1_cons_go", 64'(bus.issue_o), 64'h1);
      check("t1_dep2", 64'(bus.dep_stall_cnt_o), 64'd2);

      // Fixed latency 3 then 1.
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 3'd3, 1'b0);
      settle();
      check("t2_l3_issue", 64'(bus.issue_o), 64'h1);
      check("t2_issued2", 64'(bus.issued_cnt_o), 64'd2);
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd3, 1'b0, 5'd0, 3'd0, 1'b0);
      settle();
      check("t2_l3_t1", 64'(bus.issue_o), 64'h0);
      tick(); settle();
      check("t2_l3_t2", 64'(bus.issue_o), 64'h0);
      tick(); settle();
      check("t2_l3_t3", 64'(bus.issue_o), 64'h1);
      check("t2_dep4", 64'(bus.dep_stall_cnt_o), 64'd4);
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd3, 3'd1, 1'b0);
      settle();
      check("t2_l1_issue", 64'(bus.issue_o), 64'h1);
      tick(); idle();
      set_slot(0, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
      settle();
      check("t2_l1_t1", 64'(bus.issue_o), 64'h1);
      check("t2_issued5", 64'(bus.issued_cnt_o), 64'd5);

      // Intra-group RAW, and r0 exemption.
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 3'd1, 1'b0);
      set_slot(1, 1'b1, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
      settle();
      check("t3_raw", 64'(bus.issue_o), 64'h1);
      check("t3_issued6", 64'(bus.issued_cnt_o), 64'd6);
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 3'd2, 1'b0);
      set_slot(1, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
      settle();
      check("t3_r0", 64'(bus.issue_o), 64'h3);
      check("t3_issued7", 64'(bus.issued_cnt_o), 64'd7);

      // WAW: r4 pending with cnt=2, then shorter and longer overwrites.
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 3'd3, 1'b0);
      settle();
      check("t4_setup", 64'(bus.issue_o), 64'h1);
      check("t4_issued9", 64'(bus.issued_cnt_o), 64'd9);
      check("t4_busy0", 64'(bus.busy_o), 64'h0);
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 3'd1, 1'b0);
      settle();
      check("t4_waw_blk0", 64'(bus.issue_o), 64'h0);
      tick(); settle();
      check("t4_waw_blk1", 64'(bus.issue_o), 64'h0);
      tick(); settle();
      check("t4_waw_go", 64'(bus.issue_o), 64'h1);
      check("t4_dep6", 64'(bus.dep_stall_cnt_o), 64'd6);
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 3'd3, 1'b0);
      settle();
      check("t4_setup2", 64'(bus.issue_o), 64'h1);
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 3'd4, 1'b0);
      settle();
      check("t4_long_go", 64'(bus.issue_o), 64'h1);
      tick(); idle(); settle();
      check("t4_cnt3", 64'(bus.busy_o[4]), 64'h1);
      tick(); tick(); settle();
      check("t4_cnt1", 64'(bus.busy_o[4]), 64'h1);
      tick(); settle();
      check("t4_cnt0", 64'(bus.busy_o[4]), 64'h0);
      check("t4_issued13", 64'(bus.issued_cnt_o), 64'd13);

      // Single-issue constraints.
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b1);
      set_slot(1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
      settle();
      check("t5_si01", 64'(bus.issue_o), 64'h1);
      tick();
      bus.single_issue_i = 2'b10;
      settle();
      check("t5_si10", 64'(bus.issue_o), 64'h1);
      check("t5_issued14", 64'(bus.issued_cnt_o), 64'd14);
      tick();
      bus.single_issue_i = 2'b00;
      settle();
      check("t5_si00", 64'(bus.issue_o), 64'h3);
      check("t5_issued15", 64'(bus.issued_cnt_o), 64'd15);

      // Stall keeps counting down, flush clears, async reset clears at once.
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 3'd0, 1'b0);
      set_slot(1, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 3'd3, 1'b0);
      settle();
      check("t6_setup", 64'(bus.issue_o), 64'h3);
      check("t6_issued17", 64'(bus.issued_cnt_o), 64'd17);
      tick(); idle();
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 3'd0, 1'b0);
      bus.stall_i = 1'b1;
      settle();
      check("t6_stall_issue", 64'(bus.issue_o), 64'h0);
      check("t6_busy9", 64'(bus.busy_o[9]), 64'h1);
      check("t6_issued19", 64'(bus.issued_cnt_o), 64'd19);
      tick(); settle();
      check("t6_busy10_c1", 64'(bus.busy_o[10]), 64'h1);
      tick();
      bus.stall_i = 1'b0;
      bus.flush_i = 1'b1;
      settle();
      check("t6_flush_issue", 64'(bus.issue_o), 64'h0);
      check("t6_busy10_c0", 64'(bus.busy_o[10]), 64'h0);
      check("t6_busy9_unk", 64'(bus.busy_o[9]), 64'h1);
      tick(); idle(); settle();
      check("t6_flush_busy", 64'(bus.busy_o), 64'h0);
      check("t6_flush_issued", 64'(bus.issued_cnt_o), 64'd19);
      check("t6_flush_dep", 64'(bus.dep_stall_cnt_o), 64'd6);
      set_slot(0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 3'd0, 1'b0);
      tick(); idle(); settle();
      check("t6_rearm_busy9", 64'(bus.busy_o[9]), 64'h1);
      check("t6_issued20", 64'(bus.issued_cnt_o), 64'd20);
      #2;
      rst = 1'b1;
      #1;
      check("t6_arst_busy", 64'(bus.busy_o), 64'h0);
      check("t6_arst_issued", 64'(bus.issued_cnt_o), 64'd0);
      check("t6_arst_dep", 64'(bus.dep_stall_cnt_o), 64'd0);
      #1;
      rst = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
